// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP = 4;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched entries for the decode stage.
// Latency: a pushed entry is visible on dout the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; flush beats push.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, din         write request and data
//   pop               remove the head entry (ignored when empty)
//   flush             empty the FIFO; wins over push in the same cycle
//   dout              head entry
//   count, empty, full occupancy status
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the head slot, so a push into a full FIFO is fine in that cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: in-order imem requests, response buffering, redirect/halt handling.
// Latency: a response is presented to decode the cycle after it returns from memory.
// Backpressure: requests are credit-limited so every response has a FIFO slot; decode stalls hold the head.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   imem_req_valid/ready/addr        request channel to instruction memory
//   imem_rsp_valid/data              in-order response channel, no backpressure
//   redirect, redirect_pc            execute-stage control transfer
//   stall, hlt                       decode cannot accept / decoder reports halt
//   if_valid, if_instr, if_pc        head entry presented to decode
//   halted                           sticky halt indication
module fetch_stage #(
    parameter int              XLEN       = fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = fetch_stage_pkg::RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    input  logic            hlt,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            halted
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    fetch_stage_pkg::fetch_entry_t push_ent;
    fetch_stage_pkg::fetch_entry_t head_ent;

    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] rsp_pc, rsp_pc_nxt;
    // inflight counts live outstanding requests; drop_cnt counts outstanding
    // requests made stale by a redirect. Memory is in order, so stale ones
    // always return before any live one.
    logic [CW-1:0]   inflight, inflight_nxt;
    logic [CW-1:0]   drop_cnt, drop_cnt_nxt;
    logic            halted_nxt;

    logic [CW-1:0]   fifo_cnt;
    logic            fifo_empty;
    logic            fifo_full;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_live;
    logic            push;
    logic            pop;

    // Live requests plus buffered entries never exceed the FIFO depth, so
    // every live response is guaranteed a slot.
    assign credit_ok      = ({1'b0, inflight} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH);
    assign imem_req_valid = rst_n & ~halted & ~redirect & credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_live = imem_rsp_valid & (drop_cnt == '0);
    assign push     = rsp_live & ~halted & ~redirect;

    assign if_valid = rst_n & ~fifo_empty & ~halted;
    assign pop      = if_valid & ~stall & ~hlt & ~redirect;
    assign if_instr = head_ent.instr;
    assign if_pc    = head_ent.pc;

    assign push_ent.pc    = rsp_pc;
    assign push_ent.instr = imem_rsp_data;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_stage_pkg::fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_ent),
        .dout  (head_ent),
        .count (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        pc_nxt       = pc;
        rsp_pc_nxt   = rsp_pc;
        inflight_nxt = inflight;
        drop_cnt_nxt = drop_cnt;
        halted_nxt   = halted;
        if (redirect) begin
            pc_nxt       = redirect_pc;
            rsp_pc_nxt   = redirect_pc;
            inflight_nxt = '0;
            // Everything still outstanding is stale; a response this cycle
            // is one of them and is discarded now.
            drop_cnt_nxt = inflight + drop_cnt - CW'(imem_rsp_valid);
            halted_nxt   = 1'b0;
        end else begin
            if (req_fire) pc_nxt = pc + XLEN'(fetch_stage_pkg::PC_STEP);
            if (push)     rsp_pc_nxt = rsp_pc + XLEN'(fetch_stage_pkg::PC_STEP);
            // Live responses arriving while halted are dropped but still
            // return their credit.
            inflight_nxt = inflight + CW'(req_fire) - CW'(rsp_live);
            if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt_nxt = drop_cnt - CW'(1);
            if (if_valid && hlt) halted_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            halted   <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            rsp_pc   <= rsp_pc_nxt;
            inflight <= inflight_nxt;
            drop_cnt <= drop_cnt_nxt;
            halted   <= halted_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (inflight <= CW'(FIFO_DEPTH));
            assert (!(push && fifo_full && !pop));
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        hlt;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;

    fetch_stage #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .hlt            (hlt),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outstanding request as seen by the memory: its address, whether a
    // redirect has made it stale, and the cycle its response is due.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } os_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    os_t         m_out[$];
    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_halted;
    int          cyc;
    int          lat;

    int          checks;
    int          failures;
    bit          chk_en;
    logic [31:0] log_q[$];
    int          hs_cnt;
    int          os_now;
    int          os_peak;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int live_cnt();
        int n = 0;
        foreach (m_out[i]) if (!m_out[i].stale) n++;
        return n;
    endfunction

    function automatic bit exp_req();
        return rst_n && !m_halted && !redirect && ((live_cnt() + m_q.size()) < DEPTH);
    endfunction

    function automatic bit exp_ifv();
        return rst_n && (m_q.size() > 0) && !m_halted;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Behavioural model: outstanding request list plus an instruction queue.
    always @(posedge clk) begin : model_upd
        bit  fire;
        bit  ifv;
        bit  popq;
        os_t e;
        if (!rst_n) begin
            m_pc     = 32'h0;
            m_halted = 1'b0;
            m_q.delete();
            m_out.delete();
        end else begin
            fire = exp_req() && imem_req_ready;
            ifv  = exp_ifv();
            popq = ifv && !stall && !hlt && !redirect;
            if (popq) void'(m_q.pop_front());
            if (imem_rsp_valid && (m_out.size() > 0)) begin
                e = m_out.pop_front();
                if (!e.stale && !m_halted && !redirect) m_q.push_back('{e.addr, imem_rsp_data});
            end
            if (redirect) begin
                m_q.delete();
                foreach (m_out[i]) m_out[i].stale = 1'b1;
                m_halted = 1'b0;
                m_pc     = redirect_pc;
            end else begin
                if (ifv && hlt) m_halted = 1'b1;
                if (fire) begin
                    m_out.push_back('{m_pc, 1'b0, cyc + lat});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    end

    // Memory: in order, returns the request address as the instruction word.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if ((m_out.size() > 0) && (m_out[0].due <= cyc)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = m_out[0].addr;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin : compare
        bit er;
        bit ev;
        if (chk_en) begin
            er = exp_req();
            ev = exp_ifv();
            chk("req_valid", 32'(imem_req_valid), 32'(er));
            if (er) chk("req_addr", imem_req_addr, m_pc);
            chk("if_valid", 32'(if_valid), 32'(ev));
            if (ev) begin
                chk("if_pc", if_pc, m_q[0].pc);
                chk("if_instr", if_instr, m_q[0].instr);
            end
            chk("halted", 32'(halted), 32'(m_halted));
            if (if_valid && !stall && !hlt && !redirect) log_q.push_back(if_pc);
            if (imem_req_valid && imem_req_ready) hs_cnt++;
            os_now = os_now + int'(imem_req_valid && imem_req_ready) - int'(imem_rsp_valid);
            if (os_now > os_peak) os_peak = os_now;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        log_q.delete();
        hs_cnt  = 0;
        os_now  = 0;
        os_peak = 0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;
        hlt      = 1'b0;
        tick(2);
        clear_obs();
        rst_n = 1'b1;
    endtask

    task automatic seq_check(input string name, input logic [31:0] base);
        int bad = 0;
        foreach (log_q[i]) if (log_q[i] !== base + 32'(4 * i)) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit found;
        checks         = 0;
        failures       = 0;
        chk_en         = 1'b0;
        cyc            = 0;
        lat            = 1;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        hlt            = 1'b0;
        clear_obs();

        // Reset state
        tick(2);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        tick(1);

        // 1: streaming with a 1-cycle memory
        imem_req_ready = 1'b1;
        lat = 1;
        clear_obs();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_first_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_addr", imem_req_addr, 32'h0);
        chk("t1_first_ifv", 32'(if_valid), 32'd0);
        tick(20);
        chk("t1_pc0", log_at(0), 32'h0);
        chk("t1_pc1", log_at(1), 32'h4);
        chk("t1_pc2", log_at(2), 32'h8);
        seq_check("t1_seq", 32'h0);
        chk("t1_peak_le2", 32'(os_peak <= 2), 32'd1);

        // 2: decode stall exhausts credit
        do_reset();
        stall = 1'b1;
        tick(5);
        chk("t2_req_held", 32'(imem_req_valid), 32'd0);
        chk("t2_handshakes", 32'(hs_cnt), 32'd2);
        stall = 1'b0;
        tick(12);
        chk("t2_pc0", log_at(0), 32'h0);
        chk("t2_pc1", log_at(1), 32'h4);
        chk("t2_pc2", log_at(2), 32'h8);
        seq_check("t2_seq", 32'h0);

        // 3: redirect with two requests in flight, latency 3
        lat = 3;
        do_reset();
        tick(2);
        chk("t3_inflight", 32'(hs_cnt), 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("t3_no_req_redirect", 32'(imem_req_valid), 32'd0);
        tick(1);
        redirect = 1'b0;
        tick(16);
        chk("t3_pc0", log_at(0), 32'h100);
        chk("t3_pc1", log_at(1), 32'h104);
        seq_check("t3_seq", 32'h100);

        // 4: halt on PC 0x8, then redirect to 0x40
        lat = 1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((m_q.size() > 0) && (m_q[0].pc == 32'h8)) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        chk("t4_found_pc8", 32'(found), 32'd1);
        hlt = 1'b1;
        tick(1);
        hlt = 1'b0;
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_ifv_off", 32'(if_valid), 32'd0);
        chk("t4_if_pc_kept", if_pc, 32'h8);
        hs_cnt = 0;
        tick(5);
        chk("t4_no_reqs", 32'(hs_cnt), 32'd0);
        log_q.delete();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick(1);
        redirect = 1'b0;
        chk("t4_unhalted", 32'(halted), 32'd0);
        tick(10);
        chk("t4_resume_pc", log_at(0), 32'h40);
        seq_check("t4_seq", 32'h40);

        // 5: redirect and hlt together
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_q.size() > 0) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        chk("t5_found_head", 32'(found), 32'd1);
        log_q.delete();
        hlt         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick(1);
        hlt      = 1'b0;
        redirect = 1'b0;
        chk("t5_not_halted", 32'(halted), 32'd0);
        chk("t5_req_addr", imem_req_addr, 32'h200);
        tick(10);
        chk("t5_resume_pc", log_at(0), 32'h200);

        // 6: one-cycle reset mid-stream
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_if_valid", 32'(if_valid), 32'd0);
        tick(1);
        clear_obs();
        rst_n = 1'b1;
        #1;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_req_addr", imem_req_addr, 32'h0);
        chk("t6_if_valid", 32'(if_valid), 32'd0);
        chk("t6_halted", 32'(halted), 32'd0);
        tick(10);
        chk("t6_pc0", log_at(0), 32'h0);
        chk("t6_pc1", log_at(1), 32'h4);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
